// File: rtl/hit_data_decoder.sv
// Super-pixel hit decoder: converts the Gray TOA to binary and recovers the FTOA and
// ToT indices by stepping reference LFSRs from their seeds until each code matches.
module hit_data_decoder #(
    parameter logic [4:0] SEED5 = 5'b11111,
    parameter logic [7:0] SEED8 = 8'hFF
) (
    input  logic        clk_40MHz,
    input  logic        rst_n,
    input  logic [25:0] arbiter_data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [8:0]  toa_bin,
    output logic [4:0]  ftoa_bin,
    output logic [7:0]  tot_bin,
    output logic [3:0]  pix_addr,
    output logic [12:0] toa_fine,
    output logic        dec_err,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [25:0] word_q;
    logic [4:0]  lfsr5;
    logic [7:0]  lfsr8;
    logic [4:0]  cnt5;
    logic [7:0]  cnt8;
    logic        found5;
    logic        found8;

    logic        match5;
    logic        match8;
    logic        hit5;
    logic        hit8;
    logic        res5;
    logic        res8;
    logic [8:0]  toa_b;
    logic [4:0]  ftoa_idx;
    logic [7:0]  tot_idx;
    logic [12:0] fine_d;

    function automatic logic [8:0] gray2bin(input logic [8:0] g);
        logic [8:0] b;
        b[8] = g[8];
        for (int k = 7; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // A channel is resolved once it matched (now or earlier) or ran out of codes;
    // an exhausted channel simply stops stepping with its count parked at the limit.
    always_comb begin
        match5   = (lfsr5 == word_q[16:12]);
        match8   = (lfsr8 == word_q[11:4]);
        hit5     = found5 | match5;
        hit8     = found8 | match8;
        res5     = hit5 | (cnt5 == 5'd30);
        res8     = hit8 | (cnt8 == 8'd254);
        toa_b    = gray2bin(word_q[25:17]);
        ftoa_idx = hit5 ? cnt5 : 5'd0;
        tot_idx  = hit8 ? cnt8 : 8'd0;
        fine_d   = {toa_b - 9'd1, 4'b0000} - {8'b0, ftoa_idx};
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (data_valid) state_d = SEARCH;
            SEARCH:  if (res5 && res8) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            lfsr5    <= '0;
            lfsr8    <= '0;
            cnt5     <= '0;
            cnt8     <= '0;
            found5   <= 1'b0;
            found8   <= 1'b0;
            toa_bin  <= '0;
            ftoa_bin <= '0;
            tot_bin  <= '0;
            pix_addr <= '0;
            toa_fine <= '0;
            dec_err  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        word_q <= arbiter_data;
                        lfsr5  <= SEED5;
                        lfsr8  <= SEED8;
                        cnt5   <= '0;
                        cnt8   <= '0;
                        found5 <= 1'b0;
                        found8 <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (!res5) begin
                        lfsr5 <= {lfsr5[3:0], lfsr5[4] ^ lfsr5[2]};
                        cnt5  <= cnt5 + 5'd1;
                    end
                    if (!res8) begin
                        lfsr8 <= {lfsr8[6:0], lfsr8[7] ^ lfsr8[5] ^ lfsr8[4] ^ lfsr8[3]};
                        cnt8  <= cnt8 + 8'd1;
                    end
                    if (match5) found5 <= 1'b1;
                    if (match8) found8 <= 1'b1;
                    // The record is captured on the same edge that enters DONE.
                    if (res5 && res8) begin
                        toa_bin  <= toa_b;
                        ftoa_bin <= ftoa_idx;
                        tot_bin  <= tot_idx;
                        pix_addr <= word_q[3:0];
                        toa_fine <= fine_d;
                        dec_err  <= ~(hit5 & hit8);
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_ready = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);

endmodule

// File: tb/tb_hit_data_decoder.sv
// Scoreboard bench for hit_data_decoder: expectations are queued at word acceptance
// and compared (including latency) when out_valid rises.
module tb_hit_data_decoder;

    typedef struct {
        logic [8:0]  toa;
        logic [4:0]  ftoa;
        logic [7:0]  tot;
        logic [3:0]  addr;
        logic [12:0] fine;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk_40MHz;
    logic        rst_n;
    logic [25:0] arbiter_data;
    logic        data_valid;
    logic        data_ready;
    logic [8:0]  toa_bin;
    logic [4:0]  ftoa_bin;
    logic [7:0]  tot_bin;
    logic [3:0]  pix_addr;
    logic [12:0] toa_fine;
    logic        dec_err;
    logic        out_valid;
    logic        out_ready;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    hit_data_decoder dut (
        .clk_40MHz   (clk_40MHz),
        .rst_n       (rst_n),
        .arbiter_data(arbiter_data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .toa_bin     (toa_bin),
        .ftoa_bin    (ftoa_bin),
        .tot_bin     (tot_bin),
        .pix_addr    (pix_addr),
        .toa_fine    (toa_fine),
        .dec_err     (dec_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk_40MHz = 1'b0;
    always #10 clk_40MHz = ~clk_40MHz;

    always @(posedge clk_40MHz) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: walk each LFSR from the seed, -1 when the code never appears.
    function automatic int idx5(input logic [4:0] tgt);
        logic [4:0] q = 5'b11111;
        for (int i = 0; i < 31; i++) begin
            if (q == tgt) return i;
            q = {q[3:0], q[4] ^ q[2]};
        end
        return -1;
    endfunction

    function automatic int idx8(input logic [7:0] tgt);
        logic [7:0] q = 8'hFF;
        for (int i = 0; i < 255; i++) begin
            if (q == tgt) return i;
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
        return -1;
    endfunction

    function automatic exp_t makeExp(input logic [25:0] w);
        exp_t       e;
        int         i5, i8, l5, l8, f;
        logic [8:0] g;
        g  = w[25:17];
        for (int k = 0; k < 9; k++) e.toa[k] = ^(g >> k);
        i5 = idx5(w[16:12]);
        i8 = idx8(w[11:4]);
        e.err  = (i5 < 0) || (i8 < 0);
        e.ftoa = (i5 < 0) ? 5'd0 : 5'(i5);
        e.tot  = (i8 < 0) ? 8'd0 : 8'(i8);
        l5 = (i5 < 0) ? 30 : i5;
        l8 = (i8 < 0) ? 254 : i8;
        e.lat  = ((l5 > l8) ? l5 : l8) + 1;
        f = ((int'(e.toa) + 511) % 512) * 16 - int'(e.ftoa);
        if (f < 0) f += 8192;
        e.fine = 13'(f);
        e.addr = w[3:0];
        e.acc  = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [8:0] t, input logic [4:0] fa, input logic [7:0] tt,
                                input logic [3:0] a, input logic [12:0] fn, input logic er, input int l);
        exp_t e;
        e.toa = t; e.ftoa = fa; e.tot = tt; e.addr = a; e.fine = fn; e.err = er; e.lat = l; e.acc = 0;
        return e;
    endfunction

    always @(posedge clk_40MHz) begin
        #1;
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("latency", cyc - mon_e.acc, mon_e.lat);
                checkOutput("toa_bin", toa_bin, mon_e.toa);
                checkOutput("ftoa_bin", ftoa_bin, mon_e.ftoa);
                checkOutput("tot_bin", tot_bin, mon_e.tot);
                checkOutput("pix_addr", pix_addr, mon_e.addr);
                checkOutput("toa_fine", toa_fine, mon_e.fine);
                checkOutput("dec_err", dec_err, mon_e.err);
            end
        end
        prev_ov = out_valid;
    end

    task automatic acceptWord(input logic [25:0] w, input exp_t e, input bit track);
        @(negedge clk_40MHz);
        arbiter_data = w;
        data_valid   = 1'b1;
        checkOutput("data_ready_idle", data_ready, 1);
        @(posedge clk_40MHz);
        #1;
        e.acc = cyc;
        if (track) sb.push_back(e);
        data_valid = 1'b0;
    endtask

    task automatic waitValid();
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk_40MHz);
            n++;
        end
        if (!out_valid) begin
            checkOutput("out_valid_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic releaseRecord();
        @(negedge clk_40MHz);
        out_ready = 1'b1;
        @(posedge clk_40MHz);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_cleared", out_valid, 0);
        checkOutput("data_ready_back", data_ready, 1);
    endtask

    task automatic applyStimulus(input logic [25:0] w, input exp_t e);
        acceptWord(w, e, 1'b1);
        waitValid();
        releaseRecord();
    endtask

    logic [25:0] w_a, w_b, w_old;
    logic [4:0]  c5;
    logic [7:0]  c8;
    int          seen;

    initial begin
        rst_n        = 1'b1;
        data_valid   = 1'b0;
        out_ready    = 1'b0;
        arbiter_data = '0;
        #1 rst_n = 1'b0;
        #24;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_dec_err", dec_err, 0);
        checkOutput("rst_toa_fine", toa_fine, 0);
        checkOutput("rst_data_ready", data_ready, 1);
        @(negedge clk_40MHz);
        rst_n = 1'b1;

        w_a = {9'b000000011, 5'b11111, 8'hFF, 4'h5};
        applyStimulus(w_a, mk(9'd2, 5'd0, 8'd0, 4'h5, 13'd16, 1'b0, 1));
        w_b = {9'b0, 5'b11110, 8'hFE, 4'hA};
        applyStimulus(w_b, mk(9'd0, 5'd1, 8'd1, 4'hA, 13'd8175, 1'b0, 2));
        applyStimulus({9'b0, 5'b11111, 8'h00, 4'h3}, mk(9'd0, 5'd0, 8'd0, 4'h3, 13'd8176, 1'b1, 255));
        applyStimulus({9'b000000001, 5'b00000, 8'hFF, 4'hC}, mk(9'd1, 5'd0, 8'd0, 4'hC, 13'd0, 1'b1, 31));

        // Backpressure: record must hold and a new offer must wait for out_ready.
        acceptWord(w_a, mk(9'd2, 5'd0, 8'd0, 4'h5, 13'd16, 1'b0, 1), 1'b1);
        waitValid();
        arbiter_data = w_b;
        data_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_40MHz);
            checkOutput("hold_data_ready", data_ready, 0);
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_toa_fine", toa_fine, 16);
            checkOutput("hold_pix_addr", pix_addr, 5);
        end
        out_ready = 1'b1;
        @(posedge clk_40MHz);
        #1;
        out_ready = 1'b0;
        checkOutput("hold_release_ready", data_ready, 1);
        @(posedge clk_40MHz);
        #1;
        mon_e     = mk(9'd0, 5'd1, 8'd1, 4'hA, 13'd8175, 1'b0, 2);
        mon_e.acc = cyc;
        sb.push_back(mon_e);
        data_valid = 1'b0;
        waitValid();
        releaseRecord();

        // Reset in the middle of a long search discards the word in flight.
        w_old = {9'h055, 5'b11111, 8'h00, 4'h7};
        acceptWord(w_old, makeExp(w_old), 1'b0);
        repeat (20) @(negedge clk_40MHz);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_data_ready", data_ready, 1);
        checkOutput("midrst_toa_bin", toa_bin, 0);
        checkOutput("midrst_tot_bin", tot_bin, 0);
        checkOutput("midrst_dec_err", dec_err, 0);
        repeat (2) @(negedge clk_40MHz);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk_40MHz);
            if (out_valid) seen++;
        end
        checkOutput("no_stale_out_valid", seen, 0);
        applyStimulus(w_b, mk(9'd0, 5'd1, 8'd1, 4'hA, 13'd8175, 1'b0, 2));

        // Every FTOA code (cycling) paired with every ToT code.
        c5 = 5'b11111;
        c8 = 8'hFF;
        for (int i = 0; i < 255; i++) begin
            w_a = {9'($urandom), c5, c8, 4'($urandom)};
            applyStimulus(w_a, makeExp(w_a));
            c5 = {c5[3:0], c5[4] ^ c5[2]};
            c8 = {c8[6:0], c8[7] ^ c8[5] ^ c8[4] ^ c8[3]};
        end

        repeat (3) @(negedge clk_40MHz);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hit_data_decoder.md
HIT_DATA_DECODER -- requirements
Module: hit_data_decoder

Interface
REQ-001 SHALL have parameter SEED5, default 5'b11111, meaning FTOA LFSR code for index 0.
REQ-002 SHALL have parameter SEED8, default 8'hFF, meaning ToT LFSR code for index 0.
REQ-003 SHALL have port clk_40MHz  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port arbiter_data  input  26  super-pixel word: [25:17] Gray TOA, [16:12] FTOA LFSR, [11:4] ToT LFSR, [3:0] pixel address.
REQ-006 SHALL have port data_valid  input  1  arbiter_data valid.
REQ-007 SHALL have port data_ready  output  1  decoder can accept a word.
REQ-008 SHALL have ports toa_bin (output, 9, binary timestamp), ftoa_bin (output, 5, FTOA index), tot_bin (output, 8, ToT index) and pix_addr (output, 4, address passthrough).
REQ-009 SHALL have port toa_fine  output  13  arrival time in 1.5625 ns units.
REQ-010 SHALL have ports dec_err (output, 1, code not found) and out_valid (output, 1, decoded record valid).
REQ-011 SHALL have port out_ready  input  1  consumer accepts the record.

Function
REQ-012 SHALL implement the FSM states IDLE, SEARCH and DONE.
REQ-013 IDLE: data_ready=1; a transfer occurs on an edge with data_valid=1; on transfer the block latches the word, loads lfsr5=SEED5, lfsr8=SEED8, cnt5=0, cnt8=0, clears the found flags and moves to SEARCH.
REQ-014 data_ready SHALL be 1 only in IDLE; words offered in SEARCH or DONE are not taken.
REQ-015 FTOA LFSR step SHALL be next = {q[3:0], q[4]^q[2]}, period 31.
REQ-016 ToT LFSR step SHALL be next = {q[6:0], q[7]^q[5]^q[4]^q[3]}, period 255.
REQ-017 In each SEARCH cycle, for each channel not yet done: if lfsr equals the target, found is set and the count is held; otherwise lfsr steps and the count increments.
REQ-018 The FTOA channel SHALL be exhausted when cnt5=30 with no match; the ToT channel SHALL be exhausted when cnt8=254 with no match; an exhausted channel outputs index 0 and sets dec_err.
REQ-019 SEARCH→DONE SHALL occur on the edge where both channels are found or exhausted; all outputs register on that edge.
REQ-020 Latency: out_valid SHALL rise max(i5,i8)+1 edges after the accepting edge, where i5 and i8 are the decoded indices (exhausted channel counts as 30 or 254).
REQ-021 toa_bin SHALL be the Gray-to-binary conversion: b[8]=g[8], b[k]=b[k+1]^g[k].
REQ-022 toa_fine SHALL equal ((toa_bin-1) mod 512)*16 - ftoa_bin, modulo 8192; toa_bin=0 wraps to 511*16.
REQ-023 DONE: out_valid=1 and the outputs SHALL be held stable; on an edge with out_ready=1 the block returns to IDLE with out_valid=0; with out_ready=0 it stays in DONE indefinitely.
REQ-024 pix_addr SHALL equal arbiter_data[3:0] of the accepted word.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, data_ready=1 after release, out_valid=0, dec_err=0 and all data outputs 0.
REQ-026 Reset in SEARCH or DONE SHALL discard the word in flight; the first edge after release behaves as IDLE.

Verification
REQ-027 Word {TOA=9'b000000011, FTOA=5'b11111, ToT=8'hFF, addr=4'h5} -> out_valid 1 edge after accept, toa_bin=2, ftoa_bin=0, tot_bin=0, toa_fine=16, pix_addr=5, dec_err=0.
REQ-028 FTOA=5'b11110, ToT=8'hFE, TOA Gray=9'b0 -> ftoa_bin=1, tot_bin=1, toa_bin=0, toa_fine=8175, latency 2 edges.
REQ-029 ToT=8'h00 -> after 255 edges out_valid=1, tot_bin=0, dec_err=1; FTOA=5'b00000 gives dec_err=1 and ftoa_bin=0.
REQ-030 Hold out_ready=0 for 10 cycles with data_valid=1 -> outputs stable, data_ready=0, second word accepted only after out_ready pulse.
REQ-031 Assert rst_n=0 mid-SEARCH, then release and send a new word -> no out_valid for the old word; the new word decodes with normal latency.
REQ-032 Sweep all 31 FTOA codes and all 255 ToT codes against a reference model -> every index matches, dec_err=0, latency per REQ-020.
